// File: rtl/program_counter_pkg.sv
// Shared constants for the program counter slice:
// state encodings and the default address width.
package program_counter_pkg;

  localparam int CPU_ADDR_W = 8;

  localparam logic [1:0] PC_BOOT = 2'd0;
  localparam logic [1:0] PC_RUN  = 2'd1;
  localparam logic [1:0] PC_HALT = 2'd2;

endpackage

// File: rtl/program_counter_incrementer.sv
// Gate-level pc + 1: a ripple chain of half adders
// built entirely from two-input nand gates.
module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

module pc_incrementer #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] n1;
  logic [WIDTH-1:0] n2;
  logic [WIDTH-1:0] n3;

  // carry-in of one makes the chain an incrementer
  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    nand_gate u_n1 (
      .a (a[i]),
      .b (c[i]),
      .y (n1[i])
    );
    nand_gate u_n2 (
      .a (a[i]),
      .b (n1[i]),
      .y (n2[i])
    );
    nand_gate u_n3 (
      .a (c[i]),
      .b (n1[i]),
      .y (n3[i])
    );
    nand_gate u_sum (
      .a (n2[i]),
      .b (n3[i]),
      .y (y[i])
    );
    nand_gate u_cry (
      .a (n1[i]),
      .b (n1[i]),
      .y (c[i+1])
    );
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/program_counter.sv
// Fetch-address register: boot/run/halt control,
// next-pc mux and registered status flags.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH      = CPU_ADDR_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             halted,
  output logic             wrap
);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             valid_q;
  logic             valid_d;
  logic             halted_q;
  logic             halted_d;
  logic [WIDTH-1:0] pc_inc;
  logic             pc_cout;

  pc_incrementer #(
    .WIDTH (WIDTH)
  ) u_inc (
    .a    (pc_q),
    .y    (pc_inc),
    .cout (pc_cout)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (en) begin
          if (halt) begin
            state_d = PC_HALT;
          end else if (load) begin
            pc_d = load_addr;
          end else if (inc) begin
            pc_d   = pc_inc;
            wrap_d = pc_cout;
          end
        end
      end
      PC_HALT: begin
        if (en && resume && !halt) begin
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_BOOT;
    endcase
  end

  // status flags are registered views of the next state
  assign valid_d  = (state_d == PC_RUN);
  assign halted_d = (state_d == PC_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PC_BOOT;
      pc_q     <= RESET_ADDR;
      wrap_q   <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wrap_q   <= wrap_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = valid_q;
  assign halted   = halted_q;
  assign wrap     = wrap_q;

endmodule
